fwd_sel_unit: RTL
=================

Name: fwd_sel_unit

Overview:
- Parametrised operand-forwarding select generator for the RV32I pipeline.
- Holds a shift-register scoreboard of in-flight destination registers, DEPTH stages ahead of the decode/issue point.
- Produces per-source forwarding mux selects and forwarded operand values.
- Produces a load-use stall.
- Generalises the fixed 2-bit mux-select enums to a select width derived from DEPTH and NSRC source operands.

Parameters:
- XLEN, 32, operand data width
- DEPTH, 3, number of tracked producer slots (slot 1 = youngest, slot DEPTH = oldest/writeback)
- NSRC, 2, number of source operands resolved per cycle
- LOAD_READY, 2, lowest slot index at which a load result is forwardable

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- advance  in  1  pipeline moves one stage this cycle
- flush  in  1  squash the currently issuing instruction
- issue_valid  in  1  instruction at issue point is valid
- issue_we  in  1  issuing instruction writes rd
- issue_is_load  in  1  issuing instruction is a load
- issue_rd  in  5  issuing destination register
- issue_rs  in  NSRC*5  source register indices; source s at [s*5 +: 5]
- rf_data  in  NSRC*XLEN  register-file read data per source
- slot_data  in  DEPTH*XLEN  result value of slot k at [(k-1)*XLEN +: XLEN]
- fwd_sel  out  NSRC*SELW  per source, SELW = $clog2(DEPTH+1); 0 = regfile, k = slot k
- op_val  out  NSRC*XLEN  selected operand per source
- stall  out  1  load-use hazard; issuing instruction must hold

Behaviour:
- State: DEPTH slots, each {valid, rd[4:0], is_load}. No other state.
- Reset:
  - rst==0 at a clk edge clears all slot valid bits; rd and is_load are cleared to 0.
  - Reset overrides advance and flush.
  - After reset: fwd_sel=0, op_val=rf_data, stall=0 (all outputs are combinational from slots plus inputs).
- Match:
  - Source s matches slot k when: slot k valid, slot k rd == issue_rs[s], and issue_rs[s] != 0.
  - Slots hold only instructions with we=1 and rd!=0.
- Priority: the lowest matching k (youngest producer) wins. fwd_sel[s] = k. With no match, fwd_sel[s] = 0.
- op_val[s]:
  - Equals slot_data slot k when fwd_sel[s]=k, else rf_data[s].
  - When issue_rs[s]==0, op_val[s] is forced to 0 regardless of rf_data.
- Stall:
  - stall = issue_valid & !flush & OR over s of (winning slot k is a load and k < LOAD_READY).
  - An older non-load match never masks a younger not-ready load; the youngest producer is authoritative.
  - While stalled, fwd_sel and op_val still reflect the match; the consumer must ignore them.
- Update, only when advance==1 and rst==1:
  - Slot k+1 <= slot k for k = 1..DEPTH-1; slot DEPTH retires.
  - Slot 1 <= {1, issue_rd, issue_is_load} iff issue_valid & issue_we & issue_rd!=0 & !stall & !flush. Otherwise slot 1 <= bubble (valid=0).
- advance==0: all slots hold; stall and selects are recomputed each cycle from held state.
- flush:
  - Affects only slot-1 insertion (bubble).
  - Older slots shift normally.
  - Flush suppresses stall.
- Simultaneous flush and stall conditions: flush wins, stall=0, bubble inserted.
- DEPTH=1 is legal: SELW=1. With LOAD_READY >= 2 every load match stalls.
- Latency:
  - Selects are combinational (0 cycles).
  - A producer issued at edge N is visible in slot 1 from edge N onward and reaches slot k after k-1 further advances.

Test Plan:
- Reset: hold rst=0 for 2 cycles with garbage slot_data; release, issue_rs={x3,x4}, rf_data={0xA,0xB} -> fwd_sel={0,0}, op_val={0xA,0xB}, stall=0.
- ALU back-to-back: issue add x5 (we=1), advance; next issue_rs[0]=x5, slot_data slot1=0x1234 -> fwd_sel[0]=1, op_val[0]=0x1234, stall=0.
- Youngest wins: x5 written by slots 1 and 3 (slot1=0x11, slot3=0x33) -> fwd_sel=1, op_val=0x11. After two advances with no new x5 writer -> fwd_sel=3.
- Load-use: lw x7 in slot 1, consumer issue_rs[1]=x7 -> stall=1 and slot 1 becomes bubble on advance. Next cycle lw in slot 2 -> stall=0, fwd_sel[1]=2, op_val = slot_data slot2.
- x0 and flush: producer rd=x0 we=1 issued -> no slot entry; consumer rs=x0 with rf_data=0xFFFF -> fwd_sel=0, op_val=0. Issue lw x9 with flush=1 -> slot 1 bubble; a subsequent x9 consumer sees no match, stall=0.
- Hold and mid-op reset: advance=0 for 3 cycles with load in slot 1 -> stall stays 1, slots unchanged. Assert rst=0 -> next cycle stall=0, all fwd_sel=0.

Source files
------------

// File: rtl/fwd_sel_unit.sv
// Purpose: operand-forwarding select generator with a shift-register scoreboard of in-flight destination registers.
// Latency: selects, operand values and stall are combinational from the scoreboard and the issue-point inputs (0 cycles).
// Backpressure: stall holds the issuing instruction on a load-use hazard; advance=0 freezes the scoreboard.
module fwd_sel_unit #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_READY = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                advance,
    input  logic                                flush,
    input  logic                                issue_valid,
    input  logic                                issue_we,
    input  logic                                issue_is_load,
    input  logic [4:0]                          issue_rd,
    input  logic [NSRC*5-1:0]                   issue_rs,
    input  logic [NSRC*XLEN-1:0]                rf_data,
    input  logic [DEPTH*XLEN-1:0]               slot_data,
    output logic [NSRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
    output logic [NSRC*XLEN-1:0]                op_val,
    output logic                                stall
);

    localparam int SELW = $clog2(DEPTH+1);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    // r_slot[0] is slot 1 (youngest producer), r_slot[DEPTH-1] is the oldest
    slot_t           r_slot [DEPTH];
    logic [NSRC-1:0] w_haz;
    slot_t           w_new;

    // Per-source match: scan oldest to youngest so the youngest producer's select, data and load status win
    always_comb begin
        fwd_sel = '0;
        op_val  = '0;
        w_haz   = '0;
        for (int s = 0; s < NSRC; s++) begin
            op_val[s*XLEN +: XLEN] = rf_data[s*XLEN +: XLEN];
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_slot[k-1].vld && (r_slot[k-1].rd == issue_rs[s*5 +: 5]) &&
                    (issue_rs[s*5 +: 5] != 5'd0)) begin
                    fwd_sel[s*SELW +: SELW] = SELW'(k);
                    op_val[s*XLEN +: XLEN]  = slot_data[(k-1)*XLEN +: XLEN];
                    // a younger non-load match clears any hazard seen from an older load
                    w_haz[s] = r_slot[k-1].is_load && (k < LOAD_READY);
                end
            end
            // x0 always reads as zero, whatever the register file returns
            if (issue_rs[s*5 +: 5] == 5'd0) begin
                op_val[s*XLEN +: XLEN] = '0;
            end
        end
    end

    // Stall and slot-1 insertion: flush suppresses both; a stalled or non-writing instruction enters as a bubble
    always_comb begin
        stall = issue_valid && !flush && (|w_haz);
        w_new = '0;
        if (issue_valid && issue_we && (issue_rd != 5'd0) && !stall && !flush) begin
            w_new.vld     = 1'b1;
            w_new.rd      = issue_rd;
            w_new.is_load = issue_is_load;
        end
    end

    // Scoreboard shift: reset clears every slot, otherwise shift one stage per advance and retire the oldest
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= '0;
            end
        end else if (advance) begin
            for (int k = DEPTH-1; k >= 1; k--) begin
                r_slot[k] <= r_slot[k-1];
            end
            r_slot[0] <= w_new;
        end
    end

endmodule
